// File: rtl/sprite_pkg.sv
// Shared sprite definitions: geometry constants and capture FSM state encoding,
// common to the sprite renderer and the sprite capture block.
package sprite_pkg;

  localparam int SPRITE_SIZE  = 16;
  localparam int BITMAP_BYTES = 32;

  typedef enum logic [2:0] {
    WAIT_FOR_VSTART = 3'd0,
    WAIT_FOR_HSTART = 3'd1,
    CAPTURE         = 3'd2,
    WRITE_LO        = 3'd3,
    WRITE_HI        = 3'd4
  } capture_state_e;

endpackage

// File: rtl/sprite_capture.sv
// Captures a 16x16 monochrome sprite from a serial pixel stream into an external
// 32-byte bitmap RAM, one row per hstart, with optional horizontal/vertical mirroring.
module sprite_capture
  import sprite_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       vstart,
  input  logic       hstart,
  input  logic       pixel,
  input  logic       hmirror,
  input  logic       vmirror,
  output logic [4:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       ram_we,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAST_INDEX = 4'(SPRITE_SIZE - 1);

  capture_state_e state_q, state_d;
  logic [3:0]  ycount_q, ycount_d;
  logic [3:0]  xcount_q, xcount_d;
  logic [15:0] inbits_q, inbits_d;
  logic [4:0]  ram_addr_q, ram_addr_d;
  logic [7:0]  ram_data_q, ram_data_d;
  logic        ram_we_q, ram_we_d;
  logic        done_q, done_d;
  logic [3:0]  row_map;
  logic [3:0]  col_map;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_FOR_VSTART;
      ycount_q   <= '0;
      xcount_q   <= '0;
      inbits_q   <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_we_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ycount_q   <= ycount_d;
      xcount_q   <= xcount_d;
      inbits_q   <= inbits_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_we_q   <= ram_we_d;
      done_q     <= done_d;
    end
  end

  // Write port outputs are registered one cycle ahead so ram_we is high exactly
  // while the FSM sits in WRITE_LO / WRITE_HI, and the byte commits on leaving.
  always_comb begin
    state_d    = state_q;
    ycount_d   = ycount_q;
    xcount_d   = xcount_q;
    inbits_d   = inbits_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_we_d   = 1'b0;
    done_d     = 1'b0;
    row_map    = vmirror ? ~ycount_q : ycount_q;
    col_map    = hmirror ? ~xcount_q : xcount_q;

    case (state_q)
      WAIT_FOR_VSTART: begin
        ycount_d = '0;
        if (vstart) state_d = WAIT_FOR_HSTART;
      end
      WAIT_FOR_HSTART: begin
        xcount_d = '0;
        if (hstart) state_d = CAPTURE;
      end
      CAPTURE: begin
        inbits_d[col_map] = pixel;
        xcount_d = xcount_q + 4'd1;
        if (xcount_q == LAST_INDEX) begin
          state_d    = WRITE_LO;
          ram_we_d   = 1'b1;
          ram_addr_d = {row_map, 1'b0};
          ram_data_d = inbits_d[7:0];
        end
      end
      WRITE_LO: begin
        state_d    = WRITE_HI;
        ram_we_d   = 1'b1;
        ram_addr_d = {row_map, 1'b1};
        ram_data_d = inbits_q[15:8];
      end
      WRITE_HI: begin
        ycount_d = ycount_q + 4'd1;
        if (ycount_q == LAST_INDEX) begin
          state_d = WAIT_FOR_VSTART;
          done_d  = 1'b1;
        end else begin
          state_d = WAIT_FOR_HSTART;
        end
      end
      default: state_d = WAIT_FOR_VSTART;
    endcase
  end

  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_we   = ram_we_q;
  assign done     = done_q;
  assign busy     = (state_q != WAIT_FOR_VSTART);

endmodule

// File: tb/tb_sprite_capture.sv
// Scoreboard bench for sprite_capture: row tasks queue the expected RAM writes,
// a negedge monitor pops and compares every write and done pulse.
module tb_sprite_capture;

  logic       clk = 1'b0;
  logic       reset, vstart, hstart, pixel, hmirror, vmirror;
  logic [4:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we, busy, done;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];
  int done_pending = 0;

  logic [15:0] row_bits[16];
  logic [15:0] row_exp[16];
  logic        row_hm[16];

  sprite_capture dut (
    .clk(clk), .reset(reset), .vstart(vstart), .hstart(hstart), .pixel(pixel),
    .hmirror(hmirror), .vmirror(vmirror), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_we(ram_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin : monitor
    logic [12:0] e;
    if (!reset) begin
      if (ram_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%h", ram_addr, ram_data);
        end else begin
          e = exp_q.pop_front();
          if ({ram_addr, ram_data} !== e) begin
            errors++;
            $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                     ram_addr, ram_data, e[12:8], e[7:0]);
          end else begin
            $display("write addr=%0d data=%h ok", ram_addr, ram_data);
          end
        end
      end
      if (done) begin
        checks++;
        if (done_pending > 0) begin
          done_pending--;
          $display("done pulse ok at %0t", $time);
        end else begin
          errors++;
          $display("FAIL unexpected_done got 1 expected 0 at %0t", $time);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, expv);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [15:0] bits, input logic hm, input logic [15:0] expw);
    for (int i = 0; i < 16; i++) begin
      row_bits[i] = bits;
      row_hm[i]   = hm;
      row_exp[i]  = expw;
    end
  endtask

  // One row: hstart pulse, 16 pixels, then the two write cycles.
  task automatic do_row(input int y, input logic vm, input logic inj, input int abort_at);
    logic [3:0] yy;
    logic [3:0] ya;
    yy = y[3:0];
    ya = vm ? ~yy : yy;
    hmirror = row_hm[y];
    if (abort_at < 0) begin
      exp_q.push_back({ya, 1'b0, row_exp[y][7:0]});
      exp_q.push_back({ya, 1'b1, row_exp[y][15:8]});
    end
    hstart = 1'b1;
    tick();
    hstart = 1'b0;
    for (int k = 0; k < 16; k++) begin
      pixel  = row_bits[y][k];
      vstart = (inj && k == 5);
      tick();
      if (k == abort_at) begin
        #1 reset = 1'b1;
        #1;
        check("abort_we", 32'(ram_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        tick();
        reset = 1'b0;
        vstart = 1'b0;
        pixel = 1'b0;
        return;
      end
    end
    pixel  = 1'b0;
    vstart = 1'b0;
    hstart = inj;
    tick();
    hstart = 1'b0;
    tick();
  endtask

  task automatic do_frame(input logic vm, input logic inj, input int abort_row, input int abort_at);
    vmirror = vm;
    if (abort_row < 0) done_pending++;
    vstart = 1'b1;
    tick();
    vstart = 1'b0;
    check("busy_after_vstart", 32'(busy), 32'd1);
    for (int y = 0; y < 16; y++) begin
      if (y == abort_row) begin
        do_row(y, vm, 1'b0, abort_at);
        return;
      end
      do_row(y, vm, inj && y == 3, -1);
      if (inj && y == 3) begin
        repeat (3) tick();
        check("busy_waiting_row4", 32'(busy), 32'd1);
      end
    end
    check("busy_idle_after_frame", 32'(busy), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; vstart = 1'b0; hstart = 1'b0; pixel = 1'b0;
    hmirror = 1'b0; vmirror = 1'b0;
    tick(); tick();
    check("reset_we", 32'(ram_we), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_addr", 32'(ram_addr), 32'd0);
    check("reset_data", 32'(ram_data), 32'd0);
    reset = 1'b0;
    tick();

    // hstart and pixels while idle must not start a capture
    pixel = 1'b1; hstart = 1'b1;
    tick(); tick();
    hstart = 1'b0; pixel = 1'b0;
    repeat (20) tick();
    check("idle_busy", 32'(busy), 32'd0);

    // all ones, no mirror: 0..31 all FF
    set_all(16'hFFFF, 1'b0, 16'hFFFF);
    do_frame(1'b0, 1'b0, -1, -1);

    // single pixel at column 0 of row 0
    set_all(16'h0000, 1'b0, 16'h0000);
    row_bits[0] = 16'h0001; row_exp[0] = 16'h0001;
    do_frame(1'b0, 1'b0, -1, -1);

    set_all(16'h0000, 1'b1, 16'h0000);
    row_bits[0] = 16'h0001; row_exp[0] = 16'h8000;
    do_frame(1'b0, 1'b0, -1, -1);

    // vmirror: row 0 lands at addresses 30/31
    set_all(16'h0000, 1'b0, 16'h0000);
    row_bits[0] = 16'h3CA5; row_exp[0] = 16'h3CA5;
    do_frame(1'b1, 1'b0, -1, -1);

    // alternating hmirror per row, stray vstart/hstart around row 3
    for (int i = 0; i < 16; i++) begin
      row_bits[i] = 16'h1234;
      row_hm[i]   = i[0];
      row_exp[i]  = i[0] ? 16'h2C48 : 16'h1234;
    end
    do_frame(1'b0, 1'b1, -1, -1);

    // reset during row 5 capture, then a clean frame from row 0
    set_all(16'hFFFF, 1'b0, 16'hFFFF);
    do_frame(1'b0, 1'b0, 5, 8);
    repeat (5) tick();
    check("post_abort_busy", 32'(busy), 32'd0);
    set_all(16'h00F0, 1'b1, 16'h0F00);
    row_bits[15] = 16'h8001; row_exp[15] = 16'h8001;
    do_frame(1'b0, 1'b0, -1, -1);

    repeat (5) tick();
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check("pending_done", 32'(done_pending), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
